// File: rtl/line_follow_controller_pkg.sv
// Shared definitions for the line follower and the wheel servo handlers.
//   follower_state command encoding, tracking FSM states, turn direction.
package line_follow_controller_pkg;

  // follower_state command; 2'b10 is reserved and never driven.
  localparam logic [1:0] FOLLOW_REST  = 2'b00;
  localparam logic [1:0] FOLLOW_LEFT  = 2'b01;
  localparam logic [1:0] FOLLOW_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    FSM_IDLE    = 3'd0,
    FSM_TRACK_L = 3'd1,
    FSM_TRACK_R = 3'd2,
    FSM_SEARCH  = 3'd3,
    FSM_LOST    = 3'd4
  } fsm_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  function automatic logic [1:0] dir_to_follow(input dir_t d);
    return (d == DIR_RIGHT) ? FOLLOW_RIGHT : FOLLOW_LEFT;
  endfunction

  function automatic fsm_state_t dir_to_track(input dir_t d);
    return (d == DIR_RIGHT) ? FSM_TRACK_R : FSM_TRACK_L;
  endfunction

endpackage

// File: rtl/line_sensor_filter.sv
// One IR line sensor front end: 2-FF synchroniser, polarity normalisation
// (on line = 1), FILTER_LEN-deep sample history and registered filtered flag.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   tick         - sample strobe, one clk cycle wide
//   sensor_raw   - raw asynchronous sensor level
//   filt         - filtered on-line flag
module line_sensor_filter #(
  parameter int FILTER_LEN = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sensor_raw,
  output logic filt
);

  logic [1:0]            sync_ff;
  logic                  on_line;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_nxt;

  assign on_line  = ACTIVE_LOW ? ~sync_ff[1] : sync_ff[1];
  assign hist_nxt = {hist[FILTER_LEN-2:0], on_line};

  // filt is judged on the history including the sample taken this tick, so
  // the new value is visible in the cycle right after the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      hist    <= '0;
      filt    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], sensor_raw};
      if (tick) begin
        hist <= hist_nxt;
        if (&hist_nxt) begin
          filt <= 1'b1;
        end else if (~|hist_nxt) begin
          filt <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/line_follow_controller.sv
// Line follower front end: sample tick divider, two filtered IR sensors and
// the tracking FSM that produces the follower_state command for the wheel
// servo handlers.
// Ports:
//   clk, rst          - 100 MHz clock, synchronous active-high reset
//   enable            - run switch (asynchronous, synchronised here)
//   sensor_l/sensor_r - raw asynchronous IR sensor levels
//   follower_state    - 00 REST, 01 LEFT, 11 RIGHT
//   line_lost         - high while the line is declared lost
//   filt_l/filt_r     - filtered on-line flags
//
// state    | meaning
// IDLE     | stopped, waiting for enable and a sample tick
// TRACK_L  | line under left sensor, turn left
// TRACK_R  | line under right sensor, turn right
// SEARCH   | line gone, keep turning toward last_dir until timeout
// LOST     | search timed out, stopped with line_lost raised
module line_follow_controller
  import line_follow_controller_pkg::*;
#(
  parameter int SAMPLE_DIV        = 100000,
  parameter int FILTER_LEN        = 4,
  parameter int MIN_HOLD          = 20,
  parameter int LOST_TIMEOUT      = 500,
  parameter int SENSOR_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sensor_l,
  input  logic       sensor_r,
  output logic [1:0] follower_state,
  output logic       line_lost,
  output logic       filt_l,
  output logic       filt_r
);

  localparam int DIV_W   = $clog2(SAMPLE_DIV + 1);
  localparam int DWELL_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int LOST_W  = $clog2(LOST_TIMEOUT + 1);

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               fsm_tick;
  logic [1:0]         enable_ff;
  logic               enable_sync;

  fsm_state_t         state, state_nxt, acquire_st;
  dir_t               last_dir, last_dir_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [LOST_W-1:0]  lost_cnt, lost_cnt_nxt;
  logic [1:0]         follow_nxt;
  logic               line_lost_nxt;
  logic [1:0]         pattern;
  logic               line_seen;
  logic               dwell_done;

  // ---------------- sample tick ----------------
  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      fsm_tick <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
      fsm_tick <= tick;
    end
  end

  // ---------------- enable sync ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_ff <= '0;
    end else begin
      enable_ff <= {enable_ff[0], enable};
    end
  end
  assign enable_sync = enable_ff[1];

  // ---------------- sensor filters ----------------
  line_sensor_filter #(
    .FILTER_LEN (FILTER_LEN),
    .ACTIVE_LOW (SENSOR_ACTIVE_LOW != 0)
  ) u_filt_l (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .sensor_raw (sensor_l),
    .filt       (filt_l)
  );

  line_sensor_filter #(
    .FILTER_LEN (FILTER_LEN),
    .ACTIVE_LOW (SENSOR_ACTIVE_LOW != 0)
  ) u_filt_r (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .sensor_raw (sensor_r),
    .filt       (filt_r)
  );

  // ---------------- tracking FSM ----------------
  assign pattern    = {filt_l, filt_r};
  assign line_seen  = filt_l | filt_r;
  assign dwell_done = (dwell >= DWELL_W'(MIN_HOLD));

  // Track target when (re)acquiring the line; both sensors on line keeps the
  // last direction.
  always_comb begin
    acquire_st = dir_to_track(last_dir);
    if (pattern == 2'b10) begin
      acquire_st = FSM_TRACK_L;
    end else if (pattern == 2'b01) begin
      acquire_st = FSM_TRACK_R;
    end
  end

  always_comb begin
    state_nxt     = state;
    dwell_nxt     = dwell;
    lost_cnt_nxt  = lost_cnt;
    last_dir_nxt  = last_dir;
    follow_nxt    = FOLLOW_REST;
    line_lost_nxt = 1'b0;

    if (!enable_sync) begin
      state_nxt = FSM_IDLE;
    end else if (fsm_tick) begin
      case (state)
        FSM_IDLE: begin
          state_nxt = line_seen ? acquire_st : FSM_SEARCH;
        end
        FSM_LOST: begin
          if (line_seen) state_nxt = acquire_st;
        end
        FSM_SEARCH: begin
          // A line reappearing on the expiry tick wins over the timeout.
          if (line_seen) begin
            state_nxt = acquire_st;
          end else if (lost_cnt == LOST_W'(LOST_TIMEOUT - 1)) begin
            state_nxt = FSM_LOST;
          end else begin
            lost_cnt_nxt = lost_cnt + LOST_W'(1);
          end
        end
        FSM_TRACK_L: begin
          if (!line_seen) begin
            state_nxt = FSM_SEARCH;
          end else if (pattern == 2'b01 && dwell_done) begin
            state_nxt = FSM_TRACK_R;
          end else if (!dwell_done) begin
            dwell_nxt = dwell + DWELL_W'(1);
          end
        end
        FSM_TRACK_R: begin
          if (!line_seen) begin
            state_nxt = FSM_SEARCH;
          end else if (pattern == 2'b10 && dwell_done) begin
            state_nxt = FSM_TRACK_L;
          end else if (!dwell_done) begin
            dwell_nxt = dwell + DWELL_W'(1);
          end
        end
        default: state_nxt = FSM_IDLE;
      endcase
    end

    // Entry actions
    if (state_nxt != state) begin
      case (state_nxt)
        FSM_TRACK_L: begin
          dwell_nxt    = '0;
          last_dir_nxt = DIR_LEFT;
        end
        FSM_TRACK_R: begin
          dwell_nxt    = '0;
          last_dir_nxt = DIR_RIGHT;
        end
        FSM_SEARCH: lost_cnt_nxt = '0;
        default: ;
      endcase
    end

    // Outputs are registered alongside the state, so decode the next state.
    case (state_nxt)
      FSM_TRACK_L: follow_nxt = FOLLOW_LEFT;
      FSM_TRACK_R: follow_nxt = FOLLOW_RIGHT;
      FSM_SEARCH:  follow_nxt = dir_to_follow(last_dir_nxt);
      FSM_LOST:    line_lost_nxt = 1'b1;
      default:     follow_nxt = FOLLOW_REST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FSM_IDLE;
      last_dir       <= DIR_LEFT;
      dwell          <= '0;
      lost_cnt       <= '0;
      follower_state <= FOLLOW_REST;
      line_lost      <= 1'b0;
    end else begin
      state          <= state_nxt;
      last_dir       <= last_dir_nxt;
      dwell          <= dwell_nxt;
      lost_cnt       <= lost_cnt_nxt;
      follower_state <= follow_nxt;
      line_lost      <= line_lost_nxt;
    end
  end

endmodule

// File: tb/tb_line_follow_controller.sv
// Bench for line_follow_controller with small sim parameters. A cycle model
// of the sensor path and tracking rules is compared against the DUT on every
// negative clock edge; literal expectations at key cycles pin the model.
module tb_line_follow_controller;

  localparam int DIV  = 10;
  localparam int FLEN = 3;
  localparam int HOLD = 2;
  localparam int TMO  = 5;
  localparam int ALOW = 0;

  localparam int M_IDLE   = 0;
  localparam int M_L      = 1;
  localparam int M_R      = 2;
  localparam int M_SEARCH = 3;
  localparam int M_LOST   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sensor_l = 1'b0;
  logic       sensor_r = 1'b0;
  logic [1:0] follower_state;
  logic       line_lost;
  logic       filt_l;
  logic       filt_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  // model state
  int m_cnt;
  bit m_ftick;
  bit en_h[2];
  bit l_h[2];
  bit r_h[2];
  bit m_fl, m_fr;
  bit last_l, last_r;
  int run_l, run_r;
  int mode;
  bit m_dir;    // 0 left, 1 right
  int m_dwell;
  int m_lost;

  line_follow_controller #(
    .SAMPLE_DIV        (DIV),
    .FILTER_LEN        (FLEN),
    .MIN_HOLD          (HOLD),
    .LOST_TIMEOUT      (TMO),
    .SENSOR_ACTIVE_LOW (ALOW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sensor_l       (sensor_l),
    .sensor_r       (sensor_r),
    .follower_state (follower_state),
    .line_lost      (line_lost),
    .filt_l         (filt_l),
    .filt_r         (filt_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %b, expected %b", nm, cyc, act, exp);
    end
  endtask

  function automatic void enter_track(input int t);
    mode    = t;
    m_dwell = 0;
    m_dir   = (t == M_R);
  endfunction

  function automatic void enter_search();
    mode   = M_SEARCH;
    m_lost = 0;
  endfunction

  function automatic int pick(input bit l, input bit r);
    if (l && !r) return M_L;
    if (!l && r) return M_R;
    return m_dir ? M_R : M_L;
  endfunction

  function automatic logic [1:0] exp_follow();
    case (mode)
      M_L:      return 2'b01;
      M_R:      return 2'b11;
      M_SEARCH: return m_dir ? 2'b11 : 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

  // Reference model, one step per clock
  always @(posedge clk) begin
    bit tick_now, s, l, r;
    started = 1'b1;
    if (rst) begin
      cyc = 0;
      m_cnt = 0; m_ftick = 0;
      en_h[0] = 0; en_h[1] = 0; l_h[0] = 0; l_h[1] = 0; r_h[0] = 0; r_h[1] = 0;
      m_fl = 0; m_fr = 0;
      last_l = 0; last_r = 0; run_l = FLEN; run_r = FLEN;
      mode = M_IDLE; m_dir = 0; m_dwell = 0; m_lost = 0;
    end else begin
      cyc++;
      tick_now = (m_cnt == DIV - 1);
      l = m_fl;
      r = m_fr;
      if (!en_h[1]) begin
        mode = M_IDLE;
      end else if (m_ftick) begin
        case (mode)
          M_IDLE:   if (l || r) enter_track(pick(l, r)); else enter_search();
          M_LOST:   if (l || r) enter_track(pick(l, r));
          M_SEARCH: begin
            if (l || r) enter_track(pick(l, r));
            else if (m_lost == TMO - 1) mode = M_LOST;
            else m_lost++;
          end
          M_L: begin
            if (!l && !r) enter_search();
            else if (!l && r && m_dwell >= HOLD) enter_track(M_R);
            else if (m_dwell < HOLD) m_dwell++;
          end
          default: begin
            if (!l && !r) enter_search();
            else if (l && !r && m_dwell >= HOLD) enter_track(M_L);
            else if (m_dwell < HOLD) m_dwell++;
          end
        endcase
      end
      if (tick_now) begin
        s = l_h[1];
        if (s == last_l) run_l++; else begin last_l = s; run_l = 1; end
        if (run_l >= FLEN) m_fl = last_l;
        s = r_h[1];
        if (s == last_r) run_r++; else begin last_r = s; run_r = 1; end
        if (run_r >= FLEN) m_fr = last_r;
      end
      en_h[1] = en_h[0]; en_h[0] = enable;
      l_h[1]  = l_h[0];  l_h[0]  = (ALOW != 0) ? !sensor_l : sensor_l;
      r_h[1]  = r_h[0];  r_h[0]  = (ALOW != 0) ? !sensor_r : sensor_r;
      m_ftick = tick_now;
      m_cnt   = (m_cnt + 1) % DIV;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (started) begin
      check("model_follow", follower_state, exp_follow());
      check("model_lost", {1'b0, line_lost}, {1'b0, (mode == M_LOST)});
      check("model_filt_l", {1'b0, filt_l}, {1'b0, m_fl});
      check("model_filt_r", {1'b0, filt_r}, {1'b0, m_fr});
    end
  end

  task automatic goto(input int at);
    while (cyc < at) @(negedge clk);
    if (cyc != at) begin
      n_fail++;
      $display("FAIL schedule: at cyc %0d, wanted %0d", cyc, at);
    end
  endtask

  task automatic pin(input int at, input string nm, input logic [1:0] fs, input logic lost);
    goto(at);
    check({nm, "_follow"}, follower_state, fs);
    check({nm, "_lost"}, {1'b0, line_lost}, {1'b0, lost});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Acquire left, dwell-gated switch, search, lost, reacquire, disable
    enable = 0; sensor_l = 1; sensor_r = 0;
    do_reset();
    check("reset_follow", follower_state, 2'b00);
    check("reset_lost", {1'b0, line_lost}, 2'b00);
    check("reset_filt", {filt_l, filt_r}, 2'b00);
    goto(25); enable = 1;
    goto(29); check("acq_filt_pre", {filt_l, filt_r}, 2'b00);
    pin(30, "acq_pre", 2'b00, 0);
    check("acq_filt", {filt_l, filt_r}, 2'b10);
    pin(31, "acq_left", 2'b01, 0);

    enable = 0; sensor_l = 1; sensor_r = 1;
    do_reset();
    goto(35); sensor_l = 0;
    goto(45); enable = 1;
    pin(51, "dwell_entry", 2'b01, 0);
    goto(60); check("dwell_filt", {filt_l, filt_r}, 2'b01);
    pin(71, "dwell_hold", 2'b01, 0);
    pin(80, "dwell_hold2", 2'b01, 0);
    pin(81, "dwell_switch", 2'b11, 0);
    goto(82); sensor_r = 0;
    pin(110, "search_pre", 2'b11, 0);
    pin(111, "search_entry", 2'b11, 0);
    pin(160, "search_last", 2'b11, 0);
    pin(161, "lost_entry", 2'b00, 1);
    goto(162); sensor_l = 1;
    pin(190, "lost_hold", 2'b00, 1);
    pin(191, "lost_reacq", 2'b01, 0);
    goto(200); enable = 0;
    pin(202, "disable_pre", 2'b01, 0);
    pin(203, "disable_idle", 2'b00, 0);

    // Glitch rejection, then filter agreement on the timeout tick
    enable = 0; sensor_l = 0; sensor_r = 0;
    do_reset();
    goto(5);  sensor_l = 1;
    goto(15); sensor_l = 0;
    goto(35); check("glitch_filt", {filt_l, filt_r}, 2'b00);
    check("glitch_follow", follower_state, 2'b00);
    goto(40); enable = 1;
    pin(51, "search_left", 2'b01, 0);
    goto(75); sensor_l = 1;
    pin(100, "expiry_pre", 2'b01, 0);
    pin(101, "expiry_filter_wins", 2'b01, 0);

    // Reset during SEARCH with last_dir right
    enable = 0; sensor_l = 0; sensor_r = 1;
    do_reset();
    goto(30); enable = 1;
    pin(41, "right_entry", 2'b11, 0);
    goto(42); sensor_r = 0;
    pin(71, "right_search", 2'b11, 0);
    goto(75);
    rst = 1; enable = 0; sensor_l = 1; sensor_r = 1;
    @(negedge clk);
    check("midrst_follow", follower_state, 2'b00);
    check("midrst_lost", {1'b0, line_lost}, 2'b00);
    check("midrst_filt", {filt_l, filt_r}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 0;
    goto(30); enable = 1;
    pin(40, "postrst_pre", 2'b00, 0);
    pin(41, "postrst_lastdir", 2'b01, 0);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
